sensor_avg_alarm: RTL

Parametrised successor to the single-channel tile sensor front-end. Accepts qualified raw samples and keeps a running moving average over a power-of-two window. Drives a hysteresis alarm FSM with programmable high/low thresholds and a consecutive-hold qualifier. Sits between the tile's sensor input pins and the status/output mux; all outputs are registered.

---
 rtl/sensor_avg_alarm.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sensor_avg_alarm.sv
// Moving-average sensor front-end with a hysteresis alarm FSM and a saturating entry counter.
// Optional min/max tracking of the valid average is enabled by defining SENSOR_MINMAX_EN.
module sensor_avg_alarm #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned HOLD     = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ui_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              alarm,
  output logic [CNT_W-1:0]  alarm_count,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
);

  localparam int unsigned N      = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);

  typedef enum logic [1:0] {StWarmup, StNormal, StAlarm} state_e;

  logic [DATA_W-1:0]   r_buf [N];
  logic [SUM_W-1:0]    r_sum;
  logic [AVG_LOG2-1:0] r_wptr;
  logic [FILL_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_avg;
  logic                r_avg_valid;
  state_e              r_state, w_state_next;
  logic [HOLD_W-1:0]   r_hold, w_hold_next, w_hold_inc;
  logic                r_alarm, w_alarm_next;
  logic [CNT_W-1:0]    r_count, w_count_next;

  logic [SUM_W-1:0]    w_sum_next;
  logic [DATA_W-1:0]   w_avg;
  logic                w_full;
  logic                w_eval_normal;

  // Subtraction cannot underflow: the evicted sample is already part of r_sum.
  assign w_sum_next    = r_sum + SUM_W'(ui_in) - SUM_W'(r_buf[r_wptr]);
  assign w_avg         = w_sum_next[SUM_W-1:AVG_LOG2];
  assign w_full        = (r_fill >= FILL_W'(N - 1));
  assign w_hold_inc    = r_hold + HOLD_W'(1);
  assign w_eval_normal = (r_state == StNormal) || ((r_state == StWarmup) && w_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        r_buf[i] <= '0;
      end
      r_sum       <= '0;
      r_wptr      <= '0;
      r_fill      <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else if (sample_valid) begin
      r_buf[r_wptr] <= ui_in;
      r_sum         <= w_sum_next;
      r_wptr        <= r_wptr + AVG_LOG2'(1);
      r_avg         <= w_avg;
      if (r_fill != FILL_W'(N)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      if (w_full) begin
        r_avg_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StWarmup;
      r_hold  <= '0;
      r_alarm <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_alarm <= w_alarm_next;
      r_count <= w_count_next;
    end
  end

  // The sample that fills the window is judged under NORMAL rules on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_alarm_next = r_alarm;
    w_count_next = r_count;
    if (sample_valid) begin
      if (w_eval_normal) begin
        w_state_next = StNormal;
        if (w_avg > thr_hi) begin
          if (w_hold_inc == HOLD_W'(HOLD)) begin
            w_state_next = StAlarm;
            w_alarm_next = 1'b1;
            w_hold_next  = '0;
            if (r_count != {CNT_W{1'b1}}) begin
              w_count_next = r_count + CNT_W'(1);
            end
          end else begin
            w_hold_next = w_hold_inc;
          end
        end else begin
          w_hold_next = '0;
        end
      end else if ((r_state == StAlarm) && (w_avg < thr_lo)) begin
        w_state_next = StNormal;
        w_alarm_next = 1'b0;
      end
    end
  end

  assign avg_out     = r_avg;
  assign avg_valid   = r_avg_valid;
  assign alarm       = r_alarm;
  assign alarm_count = r_count;

`ifdef SENSOR_MINMAX_EN
  logic [DATA_W-1:0] r_min, r_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (sample_valid && w_full) begin
      if (w_avg < r_min) r_min <= w_avg;
      if (w_avg > r_max) r_max <= w_avg;
    end
  end

  assign min_out = r_min;
  assign max_out = r_max;
`else
  assign min_out = '1;
  assign max_out = '0;
`endif

endmodule
